// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash read sequencer.
// Bit counts describe one READ frame: opcode, address, data.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    CMD,
    ADDR,
    DATA,
    CS_HOLD,
    DONE
  } state_e;

  localparam logic [7:0] READ_CMD_DEF = 8'h03;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;
  localparam int BCNT_W     = 6;
  localparam int SH_W       = CMD_BITS + ADDR_BITS;

  function automatic logic is_shift(state_e s);
    return (s == CMD) || (s == ADDR) || (s == DATA);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK phase divider: H cycles low then H cycles high per bit.
// rise_en/fall_en mark the last cycle of each phase.
module spi_sclk_gen #(
  parameter int unsigned H = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic rise_en_o,
  output logic fall_en_o
);

  logic [7:0] cnt_q;
  logic       ph_q;
  logic       last;

  assign last      = (cnt_q == 8'(H - 1));
  assign rise_en_o = en_i & ~ph_q & last;
  assign fall_en_o = en_i & ph_q & last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ph_q  <= 1'b0;
    end else if (!en_i) begin
      cnt_q <= '0;
      ph_q  <= 1'b0;
    end else if (last) begin
      cnt_q <= '0;
      ph_q  <= ~ph_q;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/spi_flash_read_ctrl.sv
// Turns 6809 reads of the flash window into single-byte SPI READs,
// stretching MRDY and yielding the pins whenever the FT2232 owns them.
module spi_flash_read_ctrl
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter logic [7:0]  READ_CMD   = READ_CMD_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_spi_ce,
  input  logic        i_bus_strobe,
  input  logic        i_rw,
  input  logic [11:0] i_addr,
  input  logic        i_FT_CS,
  input  logic        i_spi_miso,
  output logic        o_spi_sclk,
  output logic        o_spi_mosi,
  output logic        o_spi_cs_n,
  output logic        o_spi_oe,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic        o_mrdy
);

  localparam logic [BCNT_W-1:0] LAST_CMD  = BCNT_W'(CMD_BITS - 1);
  localparam logic [BCNT_W-1:0] LAST_ADDR = BCNT_W'(SH_W - 1);
  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(FRAME_BITS - 1);
  localparam logic [7:0]        H_LAST    = 8'(CLK_DIV - 1);

  state_e              state_q;
  logic                cs_n_q, sclk_q, mosi_q, oe_q;
  logic                valid_q, mrdy_q;
  logic [7:0]          data_q, rx_q, cnt_q;
  logic [SH_W-1:0]     sh_q;
  logic [BCNT_W-1:0]   bit_q;
  logic                rise_en, fall_en, start;

  assign start = i_bus_strobe & i_spi_ce & i_rw;

  spi_sclk_gen #(.H(CLK_DIV)) u_sclk (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .en_i      (is_shift(state_q)),
    .rise_en_o (rise_en),
    .fall_en_o (fall_en)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      oe_q    <= 1'b0;
      data_q  <= 8'hFF;
      valid_q <= 1'b0;
      mrdy_q  <= 1'b1;
      rx_q    <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      if (state_q != IDLE && !i_FT_CS) begin
        // Programmer grabbed the flash: drop everything, hand CPU 0xFF
        state_q <= IDLE;
        cs_n_q  <= 1'b1;
        sclk_q  <= 1'b0;
        mosi_q  <= 1'b0;
        oe_q    <= 1'b0;
        data_q  <= 8'hFF;
        valid_q <= 1'b1;
        mrdy_q  <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start && i_FT_CS) begin
              state_q <= CS_SETUP;
              cs_n_q  <= 1'b0;
              oe_q    <= 1'b1;
              mrdy_q  <= 1'b0;
              cnt_q   <= '0;
              bit_q   <= '0;
              sh_q    <= {READ_CMD, FLASH_BASE + {12'h000, i_addr}};
            end else if (start) begin
              data_q  <= 8'hFF;
              valid_q <= 1'b1;
            end
          end
          CS_SETUP: begin
            if (cnt_q == H_LAST) begin
              state_q <= CMD;
              cnt_q   <= '0;
              mosi_q  <= sh_q[SH_W-1];
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          CMD, ADDR, DATA: begin
            if (rise_en) begin
              sclk_q <= 1'b1;
              if (state_q == DATA) rx_q <= {rx_q[6:0], i_spi_miso};
            end
            if (fall_en) begin
              sclk_q <= 1'b0;
              bit_q  <= bit_q + 1'b1;
              sh_q   <= {sh_q[SH_W-2:0], 1'b0};
              mosi_q <= (bit_q < LAST_ADDR) ? sh_q[SH_W-2] : 1'b0;
              if (bit_q == LAST_CMD)       state_q <= ADDR;
              else if (bit_q == LAST_ADDR) state_q <= DATA;
              else if (bit_q == LAST_BIT)  state_q <= CS_HOLD;
            end
          end
          CS_HOLD: begin
            if (cnt_q == H_LAST) begin
              state_q <= DONE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          DONE: begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            mrdy_q  <= 1'b1;
            data_q  <= rx_q;
            valid_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_spi_sclk   = sclk_q;
  assign o_spi_mosi   = mosi_q;
  assign o_spi_cs_n   = cs_n_q;
  assign o_spi_oe     = oe_q;
  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_mrdy       = mrdy_q;

endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// Scoreboard bench for spi_flash_read_ctrl with a behavioural SPI flash.
// Randomised reads, writes, FT2232 takeover, abort and reset cases.
module tb_spi_flash_read_ctrl;

  localparam int          H    = 2;
  localparam logic [23:0] BASE = 24'hFFF001;
  localparam int          LAT  = 82 * H + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_ce = 1'b0;
  logic        strobe = 1'b0;
  logic        rw = 1'b1;
  logic [11:0] addr = '0;
  logic        ft_cs = 1'b1;
  logic        miso = 1'b0;
  logic        o_spi_sclk, o_spi_mosi, o_spi_cs_n, o_spi_oe;
  logic [7:0]  o_data;
  logic        o_data_valid, o_mrdy;

  spi_flash_read_ctrl #(
    .CLK_DIV    (H),
    .FLASH_BASE (BASE),
    .READ_CMD   (8'h03)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_spi_ce     (spi_ce),
    .i_bus_strobe (strobe),
    .i_rw         (rw),
    .i_addr       (addr),
    .i_FT_CS      (ft_cs),
    .i_spi_miso   (miso),
    .o_spi_sclk   (o_spi_sclk),
    .o_spi_mosi   (o_spi_mosi),
    .o_spi_cs_n   (o_spi_cs_n),
    .o_spi_oe     (o_spi_oe),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_mrdy       (o_mrdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    bit          spi;
    logic [23:0] a;
    int          start;
    int          lat;
    bit          chk_lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] mem(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h5A;
  endfunction

  // Flash model: collect cmd+addr on SCLK rise, serve data on fall
  int          bitn = 0;
  int          rise_cnt = 0;
  logic [31:0] frame = '0;
  logic [7:0]  dbyte = '0;

  always @(posedge o_spi_sclk or negedge o_spi_cs_n) begin
    if (!o_spi_sclk) begin
      bitn = 0;
    end else if (!o_spi_cs_n && o_spi_oe) begin
      if (bitn < 32) frame = {frame[30:0], o_spi_mosi};
      bitn++;
      rise_cnt++;
      if (bitn == 32) dbyte = mem(frame[23:0]);
    end
  end

  always @(negedge o_spi_sclk) begin
    if (bitn >= 32 && bitn < 40) miso = dbyte[7-(bitn-32)];
  end

  // Monitor: pops the scoreboard on every valid pulse
  int   lo_cnt = 0;
  int   rise_base = 0;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      lo_cnt    = 0;
      rise_base = rise_cnt;
    end else begin
      chk("oe_vs_csn", {31'd0, o_spi_oe}, {31'd0, ~o_spi_cs_n});
      chk("mrdy_vs_csn", {31'd0, o_mrdy}, {31'd0, o_spi_cs_n});
      if (o_data_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {31'd0, o_data_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("data", {24'd0, o_data}, {24'd0, e.data});
          chk("latency", cyc - e.start, e.lat);
          if (e.spi) begin
            chk("frame", frame, {8'h03, e.a});
            chk("sclk_rises", rise_cnt - rise_base, 40);
          end
          if (e.chk_lo) chk("mrdy_low", lo_cnt, e.lat - 1);
        end
        lo_cnt    = 0;
        rise_base = rise_cnt;
      end else if (!o_mrdy) begin
        lo_cnt++;
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input bit s,
                          input logic [23:0] a, input int lat,
                          input bit lo);
    exp_t x;
    x.data   = d;
    x.spi    = s;
    x.a      = a;
    x.start  = cyc;
    x.lat    = lat;
    x.chk_lo = lo;
    exp_q.push_back(x);
  endtask

  task automatic issue(input logic [11:0] a, input logic r,
                       input logic ce, input bit push);
    logic [23:0] fa;
    @(negedge clk);
    addr   = a;
    rw     = r;
    spi_ce = ce;
    strobe = 1'b1;
    fa     = BASE + {12'h000, a};
    if (push && r && ce) begin
      if (ft_cs) push_exp(mem(fa), 1'b1, fa, LAT, 1'b1);
      else       push_exp(8'hFF, 1'b0, '0, 1, 1'b1);
    end
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic stray(input logic [11:0] a);
    @(negedge clk);
    addr   = a;
    rw     = 1'b1;
    spi_ce = 1'b1;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < LAT + 40; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_bits(input int n);
    for (int i = 0; i < 4 * LAT; i++) begin
      if (bitn >= n) break;
      @(negedge clk);
    end
    chk("wait_bits", {31'd0, bitn >= n}, 32'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_cs_n", {31'd0, o_spi_cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, o_spi_sclk}, 32'd0);
    chk("rst_mosi", {31'd0, o_spi_mosi}, 32'd0);
    chk("rst_oe", {31'd0, o_spi_oe}, 32'd0);
    chk("rst_data", {24'd0, o_data}, 32'hFF);
    chk("rst_valid", {31'd0, o_data_valid}, 32'd0);
    chk("rst_mrdy", {31'd0, o_mrdy}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0;
    int k;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(12'h005, 1'b1, 1'b1, 1'b1);
    wait_done();

    issue(12'h010, 1'b0, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    chk("wr_cs_n", {31'd0, o_spi_cs_n}, 32'd1);
    chk("wr_oe", {31'd0, o_spi_oe}, 32'd0);
    chk("wr_mrdy", {31'd0, o_mrdy}, 32'd1);

    ft_cs = 1'b0;
    r0 = rise_cnt;
    issue(12'h123, 1'b1, 1'b1, 1'b1);
    wait_done();
    chk("ft_no_sclk", rise_cnt - r0, 0);
    chk("ft_oe", {31'd0, o_spi_oe}, 32'd0);
    ft_cs = 1'b1;

    issue(12'h456, 1'b1, 1'b1, 1'b0);
    wait_bits(19);
    @(negedge clk);
    ft_cs = 1'b0;
    push_exp(8'hFF, 1'b0, '0, 1, 1'b0);
    wait_done();
    chk("abort_sclk", {31'd0, o_spi_sclk}, 32'd0);
    ft_cs = 1'b1;
    repeat (3) @(negedge clk);
    issue(12'h7A0, 1'b1, 1'b1, 1'b1);
    wait_done();

    issue(12'h0AB, 1'b1, 1'b1, 1'b1);
    repeat (48) @(negedge clk);
    stray(12'h0CD);
    wait_done();
    repeat (20) @(negedge clk);
    chk("single_txn_cs_n", {31'd0, o_spi_cs_n}, 32'd1);

    issue(12'h321, 1'b1, 1'b1, 1'b0);
    wait_bits(34);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(12'hFFF, 1'b1, 1'b1, 1'b1);
    wait_done();
    chk("wrap_addr", {8'd0, frame[23:0]}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      if (k <= 5) begin
        issue(12'($urandom), 1'b1, 1'b1, 1'b1);
      end else if (k == 6) begin
        issue(12'($urandom), 1'b0, 1'b1, 1'b1);
      end else if (k == 7) begin
        issue(12'($urandom), 1'b1, 1'b0, 1'b1);
      end else if (k == 8) begin
        ft_cs = 1'b0;
        issue(12'($urandom), 1'b1, 1'b1, 1'b1);
      end else begin
        issue(12'($urandom), 1'b1, 1'b1, 1'b1);
        repeat ($urandom_range(5, 120)) @(negedge clk);
        stray(12'($urandom));
      end
      wait_done();
      ft_cs = 1'b1;
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_flash_read_ctrl.md
Name: spi_flash_read_ctrl

Overview:
Sequences 6809 reads from the SPI flash window (0x3000-0x3FFF) into single-byte SPI READ (0x03) transactions.
- Input: the SPI chip-enable produced by the address decoder.
- Holds the CPU off via MRDY while the transaction runs.
- Returns the fetched byte to the CPU.
- Arbitrates the flash pins against the FT2232 programmer: whenever i_FT_CS is low, the FT2232 owns the bus and this block releases its pin drivers.

Parameters:
CLK_DIV, 2, SCLK half-period in i_clk cycles (H); legal range 1-255.
FLASH_BASE, 24'h000000, flash byte offset added to the 12-bit window offset.
READ_CMD, 8'h03, SPI read opcode.

Ports:
i_clk  in  1  system clock.
i_rst_n  in  1  asynchronous active-low reset.
i_spi_ce  in  1  flash-window select from the address decoder.
i_bus_strobe  in  1  one-cycle pulse marking a qualified CPU bus access.
i_rw  in  1  1 = read, 0 = write.
i_addr  in  12  address[11:0] within the flash window.
i_FT_CS  in  1  FT2232 flash chip select; low = FT2232 owns the flash.
i_spi_miso  in  1  flash data out.
o_spi_sclk  out  1  SPI clock, mode 0.
o_spi_mosi  out  1  SPI data to flash.
o_spi_cs_n  out  1  flash chip select, active low.
o_spi_oe  out  1  pad output-enable for sclk/mosi/cs_n; 0 = tristate.
o_data  out  8  read byte, held until the next transaction completes.
o_data_valid  out  1  one-cycle pulse when o_data is updated.
o_mrdy  out  1  to CPU MRDY; 0 = stretch the bus cycle.

Behaviour:
- Reset (async, i_rst_n low) forces the following; all outputs are registered.
  - state = IDLE, o_spi_cs_n = 1, o_spi_sclk = 0, o_spi_mosi = 0, o_spi_oe = 0.
  - o_data = 8'hFF, o_data_valid = 0, o_mrdy = 1.
- Pin ownership: o_spi_oe = 1 only when state != IDLE and i_FT_CS = 1.
- Start condition, sampled in IDLE at cycle 0: i_bus_strobe & i_spi_ce & i_rw & i_FT_CS.
  - From cycle 1: o_mrdy = 0 and o_spi_cs_n = 0.
- Write strobe (i_rw = 0) in the window: ignored. No SPI activity, o_mrdy stays 1, no valid pulse.
- Read strobe with i_FT_CS = 0: no SPI activity; at cycle 1, o_data = 8'hFF, o_data_valid = 1, o_mrdy stays 1.
- Strobes while not IDLE are ignored; no queueing.
- States and durations:
  - IDLE
  - CS_SETUP: H cycles.
  - CMD: 8 bits.
  - ADDR: 24 bits, shifted value = FLASH_BASE + {12'h0, i_addr} latched at start, MSB first, wrap mod 2^24.
  - DATA: 8 bits.
  - CS_HOLD: H cycles, sclk = 0, cs_n still 0.
  - DONE: 1 cycle.
  - Then IDLE.
- Bit timing: each bit lasts 2H cycles, SCLK low for the first H and high for the second.
  - MOSI changes only while SCLK is low (at the start of the bit).
  - MISO is sampled on the i_clk edge where SCLK rises; shifted in MSB first.
  - MOSI = 0 during DATA.
- DONE cycle:
  - o_spi_cs_n = 1, o_data = shifted byte, o_data_valid = 1.
  - o_mrdy returns to 1 in the same cycle.
- Latency: DONE = cycle 82H + 2 after the start sample (166 for H = 2).
- Abort: if i_FT_CS falls in any non-IDLE state, the next cycle goes to IDLE with:
  - o_spi_cs_n = 1, o_spi_oe = 0, o_spi_sclk = 0.
  - o_data = 8'hFF, o_data_valid = 1, o_mrdy = 1.
- Reset mid-transfer: immediate return to the reset values; no valid pulse.

Decomposition:
- Package spi_flash_pkg: state enum (IDLE, CS_SETUP, CMD, ADDR, DATA, CS_HOLD, DONE), READ_CMD default, bit-count widths (CMD 8, ADDR 24, DATA 8).
- One sub-module, spi_sclk_gen: an H-cycle divider that emits fall_en/rise_en strobes, enabled only in CMD/ADDR/DATA.

Test Plan:
- Read at 0x3005, flash model returns 0xA5, H = 2 → MOSI = 03 00 00 05; o_mrdy low cycles 1-165; o_data = 0xA5 with o_data_valid at cycle 166; cs_n high at 166.
- Write strobe to 0x3010 → cs_n stays 1, o_spi_oe stays 0, o_mrdy stays 1, no valid pulse.
- Read strobe with i_FT_CS = 0 → no SCLK edges, o_spi_oe = 0, o_data = 0xFF with valid at cycle 1, o_mrdy stays 1.
- i_FT_CS driven low during ADDR bit 10 → next cycle: cs_n = 1, oe = 0, o_data = 0xFF valid, o_mrdy = 1; a later read works normally.
- Second strobe at cycle 50 of an active read → ignored; exactly one transaction on the pins.
- i_rst_n pulsed low during DATA → all outputs at reset values asynchronously; no valid pulse; next read at 0x3FFF with FLASH_BASE = 24'hFFF001 sends address 000000 (wrap).
